spr_cr_serializer: RTL and testbench
====================================

Name: spr_cr_serializer

Overview:
Downstream consumer of the cartridge character-ROM bus CR[31:0]. Takes one 32-bit bitplane word (8 pixels × 4 planes) per load strobe and serializes it into one 4-bit colour index per clock, tagged with the sprite palette attribute, toward the line-buffer writer. It includes a two-slot buffer (hold + shift), so back-to-back words stream gaplessly.

Parameters:
PIX_PER_WORD, 8, pixels per CR word (fixed by the bus format; must not be changed)
PAL_W, 8, palette attribute width

Ports:
CLK_24M  in  1  system clock, all logic on rising edge
RESET  in  1  asynchronous, active-high reset
CR  in  32  C-ROM bitplane word; CR[7:0]=plane0, [15:8]=plane1, [23:16]=plane2, [31:24]=plane3
LOAD  in  1  one-cycle strobe: capture CR/FLIP_H/PAL_IN this edge
FLIP_H  in  1  horizontal flip for the loaded word
PAL_IN  in  PAL_W  palette attribute for the loaded word
READY  out  1  high = a LOAD this edge will be accepted
PIXEL  out  4  colour index {p3,p2,p1,p0}
PAL_OUT  out  PAL_W  palette attribute of the current pixel
PIXEL_VALID  out  1  PIXEL/PAL_OUT valid this cycle
OPAQUE  out  1  PIXEL_VALID && PIXEL!=0
WORD_DONE  out  1  pulses with the last emitted pixel of a word
OVERRUN  out  1  sticky: a LOAD arrived while READY=0

Behaviour:
- Reset (async): both slots empty, index=0. PIXEL=0, PAL_OUT=0, PIXEL_VALID=0, OPAQUE=0, WORD_DONE=0, OVERRUN=0, READY=1.
- Pixel k of a word is the bit k of each plane. Non-flipped order is k=0..7 (bit 0 is leftmost). With FLIP_H, the order is k=7..0.
- Shift-slot FSM:
  - EMPTY: a LOAD moves the word directly into the shift slot → SHIFT with idx=0.
  - SHIFT: each edge, emit pixel idx on the registered outputs, then idx++.
  - At idx=7: assert WORD_DONE with that pixel. If the hold slot is full, or a LOAD arrives on this same edge, the new word enters shift with idx=0 (no bubble). Otherwise → EMPTY.
- Hold slot: a LOAD while SHIFT and idx≠7 writes hold. The hold word transfers to shift at the idx=7 edge.
- READY = !hold_full (registered). A LOAD with READY=0 is ignored and sets OVERRUN. OVERRUN clears only on RESET.
- Latency: LOAD at edge n into an idle block → pixel 0 valid after edge n+1, pixel 7 after edge n+8.
- Throughput: one LOAD every 8 cycles gives continuous PIXEL_VALID=1.
- Outputs are registered. PIXEL/PAL_OUT hold their last value while PIXEL_VALID=0.
- Reset asserted mid-word: the word is discarded, both slots are emptied, and no partial output occurs after release.

Optional Feature:
SPR_HSHRINK_EN
- With the macro: extra input SHRINK_MASK[7:0] is captured with LOAD. Pixel k is emitted only if mask bit k=1 (mask is indexed by the source bit, before flip). Dropped pixels consume no cycle; the next kept pixel follows immediately.
  - A word with mask 0 is discarded in the cycle after transfer, with no WORD_DONE.
  - WORD_DONE marks the last kept pixel.
- Without the macro: all 8 pixels are emitted and there is no SHRINK_MASK port.

Decomposition:
- Package neo_spr_pkg: CR plane bit-slice constants, PIX_PER_WORD, pixel_t (4-bit), and the slot struct {cr, flip, pal, mask}.
- One sub-module, cr_plane_decode: combinational (cr, idx, flip) → 4-bit pixel. It is reused later by the fix-layer path.

Test Plan:
- CR=32'h000000FF, PAL_IN=8'h12, single LOAD → 8 valid cycles with PIXEL=1, PAL_OUT=12, OPAQUE=1; WORD_DONE on the 8th cycle; then PIXEL_VALID=0.
- CR=32'h01010101, FLIP_H=0 → PIXEL sequence F,0,0,0,0,0,0,0. With FLIP_H=1 → 0,0,0,0,0,0,0,F; OPAQUE only on the F pixel.
- LOADs every 8 cycles with CR=FFFFFFFF then 00000000 → 16 continuous valid cycles: 8×F then 8×0 with OPAQUE=0; no bubble; READY never low at a LOAD.
- Three LOADs on consecutive edges → the third finds READY=0, is dropped, and OVERRUN=1 (sticky). Exactly 16 pixels are output.
- RESET asserted after pixel 3 of a word with hold full → all outputs 0 asynchronously; after release READY=1 and no further PIXEL_VALID without a new LOAD.
- SPR_HSHRINK_EN, CR=32'h000000FF, mask=8'b10100101 → exactly 4 consecutive valid pixels (value 1) and WORD_DONE on the 4th. mask=0 → no output.

Source files
------------

// File: rtl/neo_spr_pkg.sv
// rtl/neo_spr_pkg.sv - shared sprite C-ROM types, plane slices and helpers
package neo_spr_pkg;

    localparam int PIX_PER_WORD = 8;
    localparam int SPR_PAL_W    = 8;
    localparam int CR_W         = 32;

    // Bit position of each bitplane byte inside a CR word
    localparam int PLANE0_LSB = 0;
    localparam int PLANE1_LSB = 8;
    localparam int PLANE2_LSB = 16;
    localparam int PLANE3_LSB = 24;

    typedef logic [3:0] pixel_t;

    typedef struct packed {
        logic [CR_W-1:0]         cr;
        logic                    flip;
        logic [SPR_PAL_W-1:0]    pal;
        logic [PIX_PER_WORD-1:0] mask;
    } slot_t;

    function automatic logic [PIX_PER_WORD-1:0] rev_bits(input logic [PIX_PER_WORD-1:0] v);
        logic [PIX_PER_WORD-1:0] r;
        for (int i = 0; i < PIX_PER_WORD; i++) begin
            r[i] = v[PIX_PER_WORD-1-i];
        end
        return r;
    endfunction

    // Keep-mask re-indexed by emission position: bit p set means the p-th pixel
    // sent out (after flip) is kept
    function automatic logic [PIX_PER_WORD-1:0] emit_order(input slot_t s);
        return s.flip ? rev_bits(s.mask) : s.mask;
    endfunction

    // Lowest set bit position; 0 when nothing is set
    function automatic logic [2:0] lowest_set(input logic [PIX_PER_WORD-1:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = PIX_PER_WORD - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = 3'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cr_plane_decode.sv
// rtl/cr_plane_decode.sv - combinational bitplane word to 4-bit pixel picker
module cr_plane_decode
    import neo_spr_pkg::*;
(
    input  logic [CR_W-1:0] cr,
    input  logic [2:0]      idx,
    input  logic            flip,
    output pixel_t          pixel
);

    logic [2:0] k;
    logic [7:0] plane0;
    logic [7:0] plane1;
    logic [7:0] plane2;
    logic [7:0] plane3;

    // idx is the emission position; flip walks the source bits from the right
    assign k      = flip ? (3'd7 - idx) : idx;
    assign plane0 = cr[PLANE0_LSB +: 8];
    assign plane1 = cr[PLANE1_LSB +: 8];
    assign plane2 = cr[PLANE2_LSB +: 8];
    assign plane3 = cr[PLANE3_LSB +: 8];
    assign pixel  = {plane3[k], plane2[k], plane1[k], plane0[k]};

endmodule

// File: rtl/spr_cr_serializer.sv
// rtl/spr_cr_serializer.sv - C-ROM word to pixel serializer with hold+shift slots; option SPR_HSHRINK_EN
module spr_cr_serializer
    import neo_spr_pkg::*;
#(
    parameter int PIX_PER_WORD = 8,
    parameter int PAL_W        = 8
) (
    input  logic             CLK_24M,
    input  logic             RESET,
    input  logic [31:0]      CR,
    input  logic             LOAD,
    input  logic             FLIP_H,
    input  logic [PAL_W-1:0] PAL_IN,
`ifdef SPR_HSHRINK_EN
    input  logic [7:0]       SHRINK_MASK,
`endif
    output logic             READY,
    output logic [3:0]       PIXEL,
    output logic [PAL_W-1:0] PAL_OUT,
    output logic             PIXEL_VALID,
    output logic             OPAQUE,
    output logic             WORD_DONE,
    output logic             OVERRUN
);

    slot_t                   shift_slot;
    slot_t                   hold_slot;
    slot_t                   load_slot;
    logic                    shift_full;
    logic                    hold_full;
    logic                    hold_full_n;
    logic [PIX_PER_WORD-1:0] rem;
    logic [PIX_PER_WORD-1:0] rem_next;
    logic [PIX_PER_WORD-1:0] load_rem;
    logic [PIX_PER_WORD-1:0] hold_rem;
    logic [2:0]              cur;
    logic                    emit;
    logic                    last;
    logic                    accept;
    pixel_t                  dec_pixel;

    cr_plane_decode u_decode (
        .cr    (shift_slot.cr),
        .idx   (cur),
        .flip  (shift_slot.flip),
        .pixel (dec_pixel)
    );

    // Next-pixel selection and slot hand-off decisions
    always_comb begin
        load_slot.cr   = CR;
        load_slot.flip = FLIP_H;
        load_slot.pal  = SPR_PAL_W'(PAL_IN);
`ifdef SPR_HSHRINK_EN
        load_slot.mask = SHRINK_MASK;
`else
        load_slot.mask = '1;
`endif
        accept   = LOAD && READY;
        load_rem = emit_order(load_slot);
        hold_rem = emit_order(hold_slot);
        // rem holds the still-to-emit positions, so skipped pixels cost no cycle
        cur      = lowest_set(rem);
        rem_next = rem & ~(PIX_PER_WORD'(1) << cur);
        emit     = shift_full && (rem != '0);
        // An all-dropped word also ends here, one edge after it entered shift
        last     = shift_full && (rem_next == '0);

        hold_full_n = hold_full;
        if (shift_full && last && hold_full) begin
            hold_full_n = 1'b0;
        end else if (shift_full && !last && accept) begin
            hold_full_n = 1'b1;
        end
    end

    // Slot state, pixel emission and status flags
    always_ff @(posedge CLK_24M or posedge RESET) begin
        if (RESET) begin
            shift_slot  <= '0;
            hold_slot   <= '0;
            shift_full  <= 1'b0;
            hold_full   <= 1'b0;
            rem         <= '0;
            READY       <= 1'b1;
            PIXEL       <= '0;
            PAL_OUT     <= '0;
            PIXEL_VALID <= 1'b0;
            OPAQUE      <= 1'b0;
            WORD_DONE   <= 1'b0;
            OVERRUN     <= 1'b0;
        end else begin
            PIXEL_VALID <= emit;
            WORD_DONE   <= emit && last;
            OPAQUE      <= emit && (dec_pixel != '0);
            if (emit) begin
                PIXEL   <= dec_pixel;
                PAL_OUT <= PAL_W'(shift_slot.pal);
            end

            if (LOAD && !READY) begin
                OVERRUN <= 1'b1;
            end

            hold_full <= hold_full_n;
            READY     <= !hold_full_n;

            if (!shift_full) begin
                if (accept) begin
                    shift_slot <= load_slot;
                    rem        <= load_rem;
                    shift_full <= 1'b1;
                end
            end else if (last) begin
                if (hold_full) begin
                    shift_slot <= hold_slot;
                    rem        <= hold_rem;
                end else if (accept) begin
                    shift_slot <= load_slot;
                    rem        <= load_rem;
                end else begin
                    shift_full <= 1'b0;
                    rem        <= '0;
                end
            end else begin
                rem <= rem_next;
                if (accept) begin
                    hold_slot <= load_slot;
                end
            end
        end
    end

endmodule

// File: tb/tb_spr_cr_serializer.sv
// tb/tb_spr_cr_serializer.sv - scoreboard bench for spr_cr_serializer
module tb_spr_cr_serializer;

    logic        clk = 1'b0;
    logic        RESET;
    logic [31:0] CR;
    logic        LOAD;
    logic        FLIP_H;
    logic [7:0]  PAL_IN;
    logic        READY;
    logic [3:0]  PIXEL;
    logic [7:0]  PAL_OUT;
    logic        PIXEL_VALID;
    logic        OPAQUE;
    logic        WORD_DONE;
    logic        OVERRUN;
`ifdef SPR_HSHRINK_EN
    localparam bit SHRINK = 1'b1;
    logic [7:0]  SHRINK_MASK;
`else
    localparam bit SHRINK = 1'b0;
`endif

    spr_cr_serializer #(.PIX_PER_WORD(8), .PAL_W(8)) dut (
        .CLK_24M     (clk),
        .RESET       (RESET),
        .CR          (CR),
        .LOAD        (LOAD),
        .FLIP_H      (FLIP_H),
        .PAL_IN      (PAL_IN),
`ifdef SPR_HSHRINK_EN
        .SHRINK_MASK (SHRINK_MASK),
`endif
        .READY       (READY),
        .PIXEL       (PIXEL),
        .PAL_OUT     (PAL_OUT),
        .PIXEL_VALID (PIXEL_VALID),
        .OPAQUE      (OPAQUE),
        .WORD_DONE   (WORD_DONE),
        .OVERRUN     (OVERRUN)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         t;
        logic [3:0] px;
        logic [7:0] pal;
        bit         done;
    } exp_t;

    exp_t q[$];
    exp_t mon_x;
    int   total = 0;
    int   bad = 0;
    int   edge_no = 0;
    int   prev_end = 0;
    int   last_a = 0;
    int   last_s = 0;
    bit   ovr_exp = 1'b0;

    always @(posedge clk) edge_no <= edge_no + 1;

    function automatic logic [3:0] ref_pixel(input logic [31:0] cr, input logic [2:0] k);
        logic [31:0] c;
        c = cr >> k;
        return {c[24], c[16], c[8], c[0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Word occupancy model: each accepted word gets an emission window [s, end];
    // a word waits in the hold slot between acceptance and its start edge.
    task automatic do_cycle(input bit ld, input logic [31:0] cr, input bit fl,
                            input logic [7:0] pal, input logic [7:0] msk);
        int         e;
        int         s;
        int         n;
        bit         rdy;
        logic [7:0] m;
        logic [2:0] k3;
        e   = edge_no + 1;
        rdy = !(last_a < e && e < last_s);
        check("ready", 32'(READY), 32'(rdy));
        check("overrun", 32'(OVERRUN), 32'(ovr_exp));
        LOAD   = ld;
        CR     = cr;
        FLIP_H = fl;
        PAL_IN = pal;
`ifdef SPR_HSHRINK_EN
        SHRINK_MASK = msk;
`endif
        if (ld) begin
            if (rdy) begin
                m = SHRINK ? msk : 8'hFF;
                s = (e + 1 > prev_end + 1) ? e + 1 : prev_end + 1;
                n = 0;
                for (int p = 0; p < 8; p++) begin
                    k3 = fl ? 3'(7 - p) : 3'(p);
                    if (m[k3]) begin
                        q.push_back('{s + n, ref_pixel(cr, k3), pal, 1'b0});
                        n++;
                    end
                end
                if (n > 0) q[q.size()-1].done = 1'b1;
                prev_end = (n == 0) ? s : s + n - 1;
                last_a   = e;
                last_s   = s;
            end else begin
                ovr_exp = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 32'h0, 1'b0, 8'h0, 8'h0);
    endtask

    task automatic reset_now();
        RESET = 1'b1;
        LOAD  = 1'b0;
        q.delete();
        prev_end = 0;
        last_a   = 0;
        last_s   = 0;
        ovr_exp  = 1'b0;
        #1;
        check("rst_pixel", 32'(PIXEL), 32'h0);
        check("rst_pal", 32'(PAL_OUT), 32'h0);
        check("rst_valid", 32'(PIXEL_VALID), 32'h0);
        check("rst_opaque", 32'(OPAQUE), 32'h0);
        check("rst_done", 32'(WORD_DONE), 32'h0);
        check("rst_overrun", 32'(OVERRUN), 32'h0);
        check("rst_ready", 32'(READY), 32'h1);
        @(posedge clk);
        #1;
        RESET = 1'b0;
    endtask

    // Monitor: pops the expected pixel scheduled for this edge, otherwise expects silence
    always @(negedge clk) begin
        if (!RESET) begin
            while (q.size() > 0 && q[0].t < edge_no) begin
                total++;
                bad++;
                $display("FAIL missing_pixel edge=%0d actual=none required=%h", q[0].t, q[0].px);
                void'(q.pop_front());
            end
            total++;
            if (q.size() > 0 && q[0].t == edge_no) begin
                mon_x = q.pop_front();
                if (!PIXEL_VALID || PIXEL !== mon_x.px || PAL_OUT !== mon_x.pal ||
                    OPAQUE !== (mon_x.px != 4'h0) || WORD_DONE !== mon_x.done) begin
                    bad++;
                    $display("FAIL pixel edge=%0d actual v=%b px=%h pal=%h op=%b wd=%b required v=1 px=%h pal=%h op=%b wd=%b",
                             edge_no, PIXEL_VALID, PIXEL, PAL_OUT, OPAQUE, WORD_DONE,
                             mon_x.px, mon_x.pal, (mon_x.px != 4'h0), mon_x.done);
                end
            end else if (PIXEL_VALID || OPAQUE || WORD_DONE) begin
                bad++;
                $display("FAIL idle edge=%0d actual v=%b op=%b wd=%b required v=0 op=0 wd=0",
                         edge_no, PIXEL_VALID, OPAQUE, WORD_DONE);
            end
        end
    end

    initial begin
        logic [7:0] rm;
        RESET  = 1'b1;
        LOAD   = 1'b0;
        CR     = '0;
        FLIP_H = 1'b0;
        PAL_IN = '0;
`ifdef SPR_HSHRINK_EN
        SHRINK_MASK = '0;
`endif
        #2;
        reset_now();

        do_cycle(1'b1, 32'h000000FF, 1'b0, 8'h12, 8'hFF);
        idle(12);

        do_cycle(1'b1, 32'h01010101, 1'b0, 8'h34, 8'hFF);
        idle(10);
        do_cycle(1'b1, 32'h01010101, 1'b1, 8'h35, 8'hFF);
        idle(10);

        do_cycle(1'b1, 32'hFFFFFFFF, 1'b0, 8'h56, 8'hFF);
        idle(7);
        do_cycle(1'b1, 32'h00000000, 1'b0, 8'h57, 8'hFF);
        idle(12);

        do_cycle(1'b1, 32'h12345678, 1'b0, 8'h01, 8'hFF);
        do_cycle(1'b1, 32'h9ABCDEF0, 1'b1, 8'h02, 8'hFF);
        do_cycle(1'b1, 32'hFFFFFFFF, 1'b0, 8'h03, 8'hFF);
        idle(20);

        do_cycle(1'b1, 32'hA5A5A5A5, 1'b0, 8'h44, 8'hFF);
        do_cycle(1'b1, 32'h5A5A5A5A, 1'b0, 8'h45, 8'hFF);
        idle(3);
        reset_now();
        idle(12);

`ifdef SPR_HSHRINK_EN
        do_cycle(1'b1, 32'h000000FF, 1'b0, 8'h66, 8'b10100101);
        idle(8);
        do_cycle(1'b1, 32'h000000FF, 1'b0, 8'h67, 8'h00);
        idle(8);
        do_cycle(1'b1, 32'hF0F0F00F, 1'b1, 8'h68, 8'b00110001);
        do_cycle(1'b1, 32'h0F0F0FF0, 1'b0, 8'h69, 8'h00);
        do_cycle(1'b1, 32'hFFFF0000, 1'b0, 8'h6A, 8'h81);
        idle(12);
`endif

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: rm = 8'h00;
                1: rm = 8'hFF;
                default: rm = 8'($urandom);
            endcase
            do_cycle($urandom_range(0, 2) == 0, $urandom, 1'($urandom), 8'($urandom), rm);
        end

        for (int i = 0; i < 6; i++) begin
            do_cycle(1'b1, $urandom, 1'($urandom), 8'($urandom), 8'hFF);
            idle(7);
        end

        idle(24);
        check("queue_empty", 32'(q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
